// File: rtl/log_luts_pkg.sv
// log_luts_pkg: rounding and table-entry helpers shared by the log2 and pow2 LUTs.
// The integer path builds the ROM contents; the real-valued helpers serve the pow2 tables.
package log_luts_pkg;

    localparam int LOG_FRAC  = 31;
    localparam int LOG_GUARD = 24;

    function automatic real roundHalfEvenReal(input real v);
        real f;
        real d;
        f = $floor(v);
        d = v - f;
        if (d > 0.5) begin
            return f + 1.0;
        end else if (d < 0.5) begin
            return f;
        end else if ($floor(f / 2.0) * 2.0 == f) begin
            return f;
        end else begin
            return f + 1.0;
        end
    endfunction

    function automatic real log2p1ScaledReal(input int in_w, input int out_w, input int i);
        return $ln(1.0 + real'(i) / (2.0 ** in_w)) / $ln(2.0) * (2.0 ** out_w);
    endfunction

    function automatic real pow2ScaledReal(input int in_w, input int out_w, input int i);
        return roundHalfEvenReal((2.0 ** (real'(i) / (2.0 ** in_w)) - 1.0) * (2.0 ** out_w));
    endfunction

    function automatic logic [63:0] rneShift(input logic [63:0] v, input int g);
        logic [63:0] q;
        logic [63:0] rem;
        logic [63:0] half;
        q    = v >> g;
        rem  = v - (q << g);
        half = 64'd1 << (g - 1);
        if ((rem > half) || ((rem == half) && q[0])) begin
            q = q + 64'd1;
        end
        return q;
    endfunction

    // Bit-serial log2 by repeated squaring of the mantissa; exact ties cannot occur
    // for i > 0, and the guard bits keep truncation far below half an output LSB.
    function automatic int exactLog2Entry(input int in_w, input int out_w, input int i);
        logic [63:0] m;
        logic [63:0] r;
        logic [63:0] e;
        r = 64'd0;
        m = (64'd1 << LOG_FRAC) + (64'(i) << (LOG_FRAC - in_w));
        for (int k = 0; k < out_w + LOG_GUARD; k++) begin
            m = (m * m) >> LOG_FRAC;
            r = r << 1;
            if (m >= (64'd2 << LOG_FRAC)) begin
                r = r | 64'd1;
                m = m >> 1;
            end
        end
        e = rneShift(r, LOG_GUARD);
        if (e >= (64'd1 << out_w)) begin
            e = (64'd1 << out_w) - 64'd1;
        end
        return int'(e);
    endfunction

    function automatic int baseEntry(input int in_w, input int out_w, input int coarse, input int j);
        return exactLog2Entry(in_w, out_w, j << (in_w - coarse));
    endfunction

    function automatic int deltaEntry(input int in_w, input int out_w, input int coarse, input int i);
        return exactLog2Entry(in_w, out_w, i) - baseEntry(in_w, out_w, coarse, i >> (in_w - coarse));
    endfunction

    // E is monotonic, so each block's largest delta sits at its last entry.
    function automatic int maxDelta(input int in_w, input int out_w, input int coarse);
        int m;
        int d;
        int last;
        m = 0;
        for (int j = 0; j < (1 << coarse); j++) begin
            last = ((j + 1) << (in_w - coarse)) - 1;
            d    = deltaEntry(in_w, out_w, coarse, last);
            if (d > m) begin
                m = d;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/log2_delta_lut_pipe_rom.sv
// log2_delta_rom: combinational coarse base table plus narrow delta table for log2(1+x).
module log2_delta_rom
    import log_luts_pkg::*;
#(
    parameter int IN     = 10,
    parameter int OUT    = 11,
    parameter int COARSE = 4,
    parameter int DW     = 8
) (
    input  logic [COARSE-1:0] i_base_idx,
    input  logic [IN-1:0]     i_delta_idx,
    output logic [OUT-1:0]    o_base,
    output logic [DW-1:0]     o_delta
);
    localparam int NBASE  = 1 << COARSE;
    localparam int NDELTA = 1 << IN;

    logic [OUT-1:0] w_base_tab  [NBASE];
    logic [DW-1:0]  w_delta_tab [NDELTA];

    for (genvar j = 0; j < NBASE; j++) begin : g_base
        assign w_base_tab[j] = OUT'(baseEntry(IN, OUT, COARSE, j));
    end

    for (genvar k = 0; k < NDELTA; k++) begin : g_delta
        assign w_delta_tab[k] = DW'(deltaEntry(IN, OUT, COARSE, k));
    end

    if (maxDelta(IN, OUT, COARSE) >= (1 << DW)) begin : g_dw_check
        $error("log2_delta_rom: delta of %0d does not fit in DW=%0d bits", maxDelta(IN, OUT, COARSE), DW);
    end

    assign o_base  = w_base_tab[i_base_idx];
    assign o_delta = w_delta_tab[i_delta_idx];

endmodule

// File: rtl/log2_delta_lut_pipe.sv
// log2_delta_lut_pipe: two-stage valid/ready log2(1+x) fraction unit over a delta ROM.
// Define LOG2_DELTA_LUT_CHECK_EN to add a direct-table cross-check with sticky mismatch.
module log2_delta_lut_pipe
    import log_luts_pkg::*;
#(
    parameter int IN     = 10,
    parameter int OUT    = 11,
    parameter int COARSE = 4,
    parameter int DW     = 8
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           inValid,
    output logic           inReady,
    input  logic [IN-1:0]  in,
    output logic           outValid,
    input  logic           outReady,
    output logic [OUT-1:0] out,
    output logic           mismatch
);
    logic           r_s1_valid;
    logic [IN-1:0]  r_s1_idx;
    logic           r_s2_valid;
    logic [OUT-1:0] r_s2_out;
    logic           w_s2_adv;
    logic           w_s1_load;
    logic [OUT-1:0] w_base;
    logic [DW-1:0]  w_delta;
    logic [OUT-1:0] w_sum;

    assign w_s2_adv  = !r_s2_valid || outReady;
    assign w_s1_load = !r_s1_valid || w_s2_adv;
    assign inReady   = w_s1_load;
    assign w_sum     = w_base + OUT'(w_delta);
    assign outValid  = r_s2_valid;
    assign out       = r_s2_out;

    log2_delta_rom #(
        .IN     (IN),
        .OUT    (OUT),
        .COARSE (COARSE),
        .DW     (DW)
    ) u_rom (
        .i_base_idx  (r_s1_idx[IN-1:IN-COARSE]),
        .i_delta_idx (r_s1_idx),
        .o_base      (w_base),
        .o_delta     (w_delta)
    );

    // Stage 1: capture the accepted fraction as the table index.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_idx   <= {IN{1'b0}};
        end else if (w_s1_load) begin
            r_s1_valid <= inValid;
            if (inValid) begin
                r_s1_idx <= in;
            end else begin
                r_s1_idx <= r_s1_idx;
            end
        end else begin
            r_s1_valid <= r_s1_valid;
            r_s1_idx   <= r_s1_idx;
        end
    end

    // Stage 2: register base + delta; held while the consumer stalls.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_s2_out   <= {OUT{1'b0}};
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_out <= w_sum;
            end else begin
                r_s2_out <= r_s2_out;
            end
        end else begin
            r_s2_valid <= r_s2_valid;
            r_s2_out   <= r_s2_out;
        end
    end

`ifdef LOG2_DELTA_LUT_CHECK_EN
    localparam int NEXACT = 1 << IN;

    logic [OUT-1:0] w_exact_tab [NEXACT];
    logic [IN-1:0]  r_s2_idx;
    logic           r_mismatch;
    logic           w_out_xfer;

    for (genvar k = 0; k < NEXACT; k++) begin : g_exact
        assign w_exact_tab[k] = OUT'(exactLog2Entry(IN, OUT, k));
    end

    assign w_out_xfer = r_s2_valid && outReady;
    assign mismatch   = r_mismatch;

    // Index travels with the data so the output can be checked against the direct table.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s2_idx <= {IN{1'b0}};
        end else if (w_s2_adv && r_s1_valid) begin
            r_s2_idx <= r_s1_idx;
        end else begin
            r_s2_idx <= r_s2_idx;
        end
    end

    // Sticky disagreement flag, cleared only by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_mismatch <= 1'b0;
        end else if (w_out_xfer && (r_s2_out != w_exact_tab[r_s2_idx])) begin
            r_mismatch <= 1'b1;
        end else begin
            r_mismatch <= r_mismatch;
        end
    end

    // Report each disagreeing transfer with its index and both values.
    always_ff @(posedge clock) begin
        if (!reset && w_out_xfer) begin
            assert (r_s2_out == w_exact_tab[r_s2_idx])
            else $warning("log2_delta_lut_pipe: index %0d gave %0d, direct table holds %0d",
                          r_s2_idx, r_s2_out, w_exact_tab[r_s2_idx]);
        end
    end
`else
    assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_log2_delta_lut_pipe.sv
// Scoreboard bench for log2_delta_lut_pipe: three configurations driven with directed vectors.
module tb_log2_delta_lut_pipe;

    typedef struct {
        int exp;
        int acc;
        bit lat;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_fail;

    // small: IN=4 OUT=5 COARSE=2 DW=5
    logic       s_valid, s_ready, s_in_ready, s_out_valid, s_mm;
    logic [3:0] s_in;
    logic [4:0] s_out;
    // default: IN=10 OUT=11 COARSE=4 DW=8
    logic        d_valid, d_ready, d_in_ready, d_out_valid, d_mm;
    logic [9:0]  d_in;
    logic [10:0] d_out;
    // clamp: IN=10 OUT=4 COARSE=4 DW=4
    logic       c_valid, c_ready, c_in_ready, c_out_valid, c_mm;
    logic [9:0] c_in;
    logic [3:0] c_out;

    exp_t q_s[$];
    exp_t q_d[$];
    exp_t q_c[$];
    exp_t e_s, e_d, e_c;
    logic        d_hold_v;
    logic [10:0] d_hold;

    int bp_words[3] = '{512, 1023, 0};
    int bp_exp[3]   = '{1198, 2047, 0};
    int bp_acc;

    log2_delta_lut_pipe #(.IN(4), .OUT(5), .COARSE(2), .DW(5)) u_small (
        .clock(clk), .reset(rst), .inValid(s_valid), .inReady(s_in_ready), .in(s_in),
        .outValid(s_out_valid), .outReady(s_ready), .out(s_out), .mismatch(s_mm));

    log2_delta_lut_pipe #(.IN(10), .OUT(11), .COARSE(4), .DW(8)) u_dflt (
        .clock(clk), .reset(rst), .inValid(d_valid), .inReady(d_in_ready), .in(d_in),
        .outValid(d_out_valid), .outReady(d_ready), .out(d_out), .mismatch(d_mm));

    log2_delta_lut_pipe #(.IN(10), .OUT(4), .COARSE(4), .DW(4)) u_clamp (
        .clock(clk), .reset(rst), .inValid(c_valid), .inReady(c_in_ready), .in(c_in),
        .outValid(c_out_valid), .outReady(c_ready), .out(c_out), .mismatch(c_mm));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input int act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %0d with nothing expected", name, act);
    endtask

    // Round-half-even of log2(1+i/2^in_w)*2^out_w, clamped to the output range.
    function automatic int model_e(input int in_w, input int out_w, input int i);
        real v;
        real f;
        int  r;
        v = $ln(1.0 + real'(i) / (2.0 ** in_w)) / $ln(2.0) * (2.0 ** out_w);
        f = $floor(v);
        r = $rtoi(f);
        if (v - f > 0.5) r++;
        else if ((v - f == 0.5) && (r % 2 == 1)) r++;
        if (r >= (1 << out_w)) r = (1 << out_w) - 1;
        return r;
    endfunction

    function automatic int qsize(input int which);
        case (which)
            0: return q_s.size();
            1: return q_d.size();
            2: return q_c.size();
            default: return 0;
        endcase
    endfunction

    // Monitors: compare each output transfer against the head of its queue.
    always @(negedge clk) begin
        if (!rst && s_out_valid && s_ready) begin
            if (q_s.size() == 0) flag("s_extra_word", int'(s_out));
            else begin
                e_s = q_s.pop_front();
                chk("s_out", int'(s_out), e_s.exp);
                if (e_s.lat) chk("s_latency", cyc - e_s.acc, 2);
            end
        end
    end

    always @(negedge clk) begin
        if (rst || !d_out_valid) begin
            d_hold_v <= 1'b0;
        end else begin
            if (d_hold_v) chk("d_stable_while_stalled", int'(d_out), int'(d_hold));
            if (d_ready) begin
                d_hold_v <= 1'b0;
                if (q_d.size() == 0) flag("d_extra_word", int'(d_out));
                else begin
                    e_d = q_d.pop_front();
                    chk("d_out", int'(d_out), e_d.exp);
                    if (e_d.lat) chk("d_latency", cyc - e_d.acc, 2);
                end
            end else begin
                d_hold_v <= 1'b1;
                d_hold   <= d_out;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && c_out_valid && c_ready) begin
            if (q_c.size() == 0) flag("c_extra_word", int'(c_out));
            else begin
                e_c = q_c.pop_front();
                chk("c_out", int'(c_out), e_c.exp);
                if (e_c.lat) chk("c_latency", cyc - e_c.acc, 2);
            end
        end
    end

    task automatic send_s(input int v, input int e, input bit lat);
        int tries = 0;
        s_in = 4'(v);
        s_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (s_in_ready) begin
                q_s.push_back('{exp: e, acc: cyc, lat: lat});
                @(posedge clk); #1;
                break;
            end
            tries++;
            if (tries > 200) begin
                flag("s_send_timeout", v);
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic send_d(input int v, input int e, input bit lat, input bit rnd);
        int tries = 0;
        d_in = 10'(v);
        d_valid = 1'b1;
        forever begin
            if (rnd) d_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (d_in_ready) begin
                q_d.push_back('{exp: e, acc: cyc, lat: lat});
                @(posedge clk); #1;
                break;
            end
            tries++;
            if (tries > 200) begin
                flag("d_send_timeout", v);
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic send_c(input int v, input int e, input bit lat);
        int tries = 0;
        c_in = 10'(v);
        c_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (c_in_ready) begin
                q_c.push_back('{exp: e, acc: cyc, lat: lat});
                @(posedge clk); #1;
                break;
            end
            tries++;
            if (tries > 200) begin
                flag("c_send_timeout", v);
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic drain(input string name, input int which);
        int n = 0;
        while ((qsize(which) != 0) && (n < 400)) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, qsize(which), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cyc = 0; n_checks = 0; n_fail = 0;
        s_valid = 1'b0; s_ready = 1'b1; s_in = 4'd0;
        d_valid = 1'b0; d_ready = 1'b1; d_in = 10'd0;
        c_valid = 1'b0; c_ready = 1'b1; c_in = 10'd0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_s_out_valid", int'(s_out_valid), 0);
        chk("rst_s_out", int'(s_out), 0);
        chk("rst_s_in_ready", int'(s_in_ready), 1);
        chk("rst_d_out_valid", int'(d_out_valid), 0);
        chk("rst_d_out", int'(d_out), 0);
        chk("rst_d_in_ready", int'(d_in_ready), 1);
        chk("rst_c_out", int'(c_out), 0);
        chk("rst_d_mismatch", int'(d_mm), 0);
        @(posedge clk); #1;

        // back-to-back stream, 2-cycle latency each
        send_s(0, 0, 1'b1);
        send_s(1, 3, 1'b1);
        send_s(8, 19, 1'b1);
        send_s(15, 31, 1'b1);
        send_s(4, 10, 1'b1);
        s_valid = 1'b0;
        drain("s_stream_drained", 0);

        // fill both stages, then reset mid-stream
        s_ready = 1'b0;
        send_s(1, 3, 1'b0);
        send_s(15, 31, 1'b0);
        s_valid = 1'b0;
        @(negedge clk);
        chk("s_full_in_ready", int'(s_in_ready), 0);
        chk("s_full_out_valid", int'(s_out_valid), 1);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("s_async_out_valid", int'(s_out_valid), 0);
        chk("s_async_out", int'(s_out), 0);
        q_s.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        s_ready = 1'b1;
        @(negedge clk);
        chk("s_post_rst_in_ready", int'(s_in_ready), 1);
        @(posedge clk); #1;
        send_s(8, 19, 1'b1);
        s_valid = 1'b0;
        drain("s_post_rst_drained", 0);

        // clamp configuration
        send_c(1023, 15, 1'b1);
        send_c(0, 0, 1'b1);
        send_c(512, 9, 1'b1);
        send_c(256, 5, 1'b1);
        c_valid = 1'b0;
        drain("c_drained", 2);

        // default configuration, directed
        send_d(512, 1198, 1'b1, 1'b0);
        send_d(1023, 2047, 1'b1, 1'b0);
        send_d(0, 0, 1'b1, 1'b0);
        send_d(1, 3, 1'b1, 1'b0);
        d_valid = 1'b0;
        drain("d_directed_drained", 1);

        // backpressure: outReady low for 5 cycles with inValid held high
        d_ready = 1'b0;
        bp_acc = 0;
        d_in = 10'(bp_words[0]);
        d_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (d_in_ready && (bp_acc < 3)) begin
                q_d.push_back('{exp: bp_exp[bp_acc], acc: cyc, lat: 1'b0});
                bp_acc++;
            end
            @(posedge clk); #1;
            if (bp_acc < 3) d_in = 10'(bp_words[bp_acc]);
        end
        chk("bp_words_accepted", bp_acc, 2);
        @(negedge clk);
        chk("bp_in_ready", int'(d_in_ready), 0);
        chk("bp_out_valid", int'(d_out_valid), 1);
        @(posedge clk); #1;
        d_ready = 1'b1;
        if (bp_acc < 3) send_d(bp_words[bp_acc], bp_exp[bp_acc], 1'b0, 1'b0);
        d_valid = 1'b0;
        drain("bp_drained", 1);

        // full sweep with random gaps and random backpressure
        for (int i = 0; i < 1024; i++) begin
            while ($urandom_range(0, 3) == 0) begin
                d_valid = 1'b0;
                d_ready = ($urandom_range(0, 3) != 0);
                @(posedge clk); #1;
            end
            send_d(i, model_e(10, 11, i), 1'b0, 1'b1);
        end
        d_valid = 1'b0;
        d_ready = 1'b1;
        drain("sweep_drained", 1);

`ifdef LOG2_DELTA_LUT_CHECK_EN
        chk("d_mismatch_clean", int'(d_mm), 0);
        force u_dflt.u_rom.o_delta = 8'd0;
        send_d(5, 0, 1'b0, 1'b0);
        d_valid = 1'b0;
        drain("d_forced_drained", 1);
        release u_dflt.u_rom.o_delta;
        @(negedge clk);
        chk("d_mismatch_set", int'(d_mm), 1);
        @(posedge clk); #1;
        send_d(0, 0, 1'b0, 1'b0);
        d_valid = 1'b0;
        drain("d_after_force_drained", 1);
        @(negedge clk);
        chk("d_mismatch_sticky", int'(d_mm), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("d_mismatch_reset", int'(d_mm), 0);
        @(posedge clk); #1;
        rst = 1'b0;
`endif

        @(negedge clk);
        chk("end_s_mismatch", int'(s_mm), 0);
        chk("end_d_mismatch", int'(d_mm), 0);
        chk("end_c_mismatch", int'(c_mm), 0);
        chk("end_d_idle", int'(d_out_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/log2_delta_lut_pipe.md
Name: log2_delta_lut_pipe

Overview:
- Pipelined fixed-point fraction log2 unit, the linear-to-log direction that mirrors the existing pow2 LUTs.
- Computes log2(1 + x) for x = in/2^IN in [0,1) and returns an OUT-bit fraction.
- The table is stored delta-compressed: a coarse base table plus a narrow delta table.
- Sits at the front of the log-domain converter, feeding the fractional part to the log accumulator; valid/ready streaming with full throughput.

Parameters:
- IN, 10, input fraction width; 2^IN table entries.
- OUT, 11, output fraction width.
- COARSE, 4, index bits for the base table (1 ≤ COARSE < IN); base has 2^COARSE entries.
- DW, 8, delta table entry width (unsigned); elaboration-time assertion that every delta fits.

Ports:
- clock, input, 1, single clock.
- reset, input, 1, asynchronous, active-high.
- inValid, input, 1, input word valid.
- inReady, output, 1, unit can accept a word this cycle.
- in, input, IN, fraction x.
- outValid, output, 1, result valid.
- outReady, input, 1, consumer accepts result.
- out, output, OUT, log2(1+x) fraction.
- mismatch, output, 1, sticky self-check flag (Optional Feature).

Behaviour:
- Exact function: E[i] = round-half-even(log2(1 + i/2^IN) * 2^OUT). If the rounded value equals 2^OUT, clamp it to 2^OUT-1.
- Tables are built by elaboration-time constant functions:
  - base[j] = E[j << (IN-COARSE)]
  - delta[i] = E[i] - base[i >> (IN-COARSE)]
  - E is monotonic non-decreasing, so every delta is ≥ 0.
- Stage 1 (on accept): register in[IN-1:IN-COARSE] → base lookup, and in → delta lookup. Also register the valid bit.
- Stage 2: out = base + zero-extended delta. The sum is OUT bits wide and never exceeds 2^OUT-1.
- Latency is exactly 2 cycles from the accepting edge to outValid, with no bubbles when outReady stays high.
- Handshake:
  - Transfer occurs when valid && ready at a clock edge.
  - s2 advances when !s2Valid || outReady.
  - inReady = !s1Valid || s2 advances. This is combinational from outReady with no register in between; it is documented as allowed.
  - Once outValid is asserted, out stays stable and outValid stays high until accepted.
- Backpressure (outReady low): both stages fill, then inReady drops. No data is lost or duplicated.
- Simultaneous accept and emit in the same cycle is allowed; the pipeline shifts.
- Reset (asynchronous, any time, including mid-stream):
  - s1Valid and s2Valid clear to 0, so outValid = 0.
  - out registers clear to 0 and mismatch clears to 0.
  - inReady = 1 while reset is deasserted and both stages are empty.
  - In-flight words are discarded.
- out is don't-care when outValid = 0, but is held at its reset value until the first result.

Optional Feature:
- Macro LOG2_DELTA_LUT_CHECK_EN.
- When defined:
  - A full direct table E[] is instantiated, and the input index is pipelined alongside the data.
  - At every output transfer, out is compared against E[index]. A difference sets sticky mismatch (cleared only by reset) and fires an immediate assertion printing the index and both values.
- When undefined: mismatch is tied to 0, and no direct table or index pipeline is built.

Decomposition:
- Shared package log_luts_pkg:
  - real-valued helper functions: round-half-even, log2(1+x) scaled.
  - constant functions: exactLog2Entry(IN, OUT, i), baseEntry, deltaEntry, maxDelta (used for the DW assertion).
  - The pow2 LUTs are refactored to reuse the rounding helper.
- One natural sub-module: log2_delta_rom, a combinational base and delta table pair parameterized by IN/OUT/COARSE/DW. The pipe instantiates it between its registers.

Test Plan:
- IN=4, OUT=5, COARSE=2, DW=5; stream in = 0, 1, 8, 15 with outReady=1 → out = 0, 3, 19, 31; each outValid 2 cycles after accept, back-to-back.
- IN=10, OUT=11 defaults; sweep all 1024 inputs with random inValid/outReady → in-order results equal E[i] (e.g. in=1023 → 2047, in=512 → 1198); mismatch=0 with the macro defined.
- IN=10, OUT=4 clamp case → in=1023 gives 15 (not 16); in=0 gives 0.
- Backpressure: hold outReady=0 for 5 cycles while inValid=1 → exactly 2 words are accepted, then inReady=0. Release → words emerge in order, nothing dropped or duplicated.
- Assert reset mid-stream with both stages full → outValid drops asynchronously; after release inReady=1 and the next input (in=8, IN=4/OUT=5) yields 19 after 2 cycles.
- With LOG2_DELTA_LUT_CHECK_EN, force the delta ROM output wrong via bench override at in=5 → mismatch rises at that output transfer and stays high until reset.
